// File: rtl/melody_sequencer.sv
// Autonomous 8-note tune player: a fixed note ROM drives one shared square-wave divider.
// Optional `MELODY_SEQUENCER_TRANSPOSE_EN adds octave_up, which halves the divider per note.
module melody_sequencer #(
  parameter int unsigned clock_frequency = 50000000,
  parameter int unsigned unit_cycles     = 6250000,
  parameter int unsigned gap_cycles      = 1000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
`ifdef MELODY_SEQUENCER_TRANSPOSE_EN
  input  logic       octave_up,
`endif
  output logic       busy,
  output logic [2:0] note_index,
  output logic       tone
);

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned HALF_W = 24;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned DUR_W  = 3;

  function automatic logic [HALF_W-1:0] calc_half(input int unsigned f_mul_100);
    longint unsigned ticks;
    ticks     = (64'(clock_frequency) * 64'd100) / 64'(f_mul_100);
    calc_half = HALF_W'(ticks / 64'd2);
  endfunction

  localparam logic [HALF_W-1:0] HALF_C4 = calc_half(26163);
  localparam logic [HALF_W-1:0] HALF_D4 = calc_half(29366);
  localparam logic [HALF_W-1:0] HALF_E4 = calc_half(32963);
  localparam logic [HALF_W-1:0] HALF_F4 = calc_half(34923);
  localparam logic [HALF_W-1:0] HALF_G4 = calc_half(39200);
  localparam logic [HALF_W-1:0] HALF_A4 = calc_half(44000);
  localparam logic [HALF_W-1:0] HALF_B4 = calc_half(49388);
  localparam logic [HALF_W-1:0] HALF_C5 = calc_half(52325);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(gap_cycles - 1);

  function automatic logic [HALF_W-1:0] note_half(input logic [CODE_W-1:0] code);
    case (code)
      4'd1:    note_half = HALF_C4;
      4'd2:    note_half = HALF_D4;
      4'd3:    note_half = HALF_E4;
      4'd4:    note_half = HALF_F4;
      4'd5:    note_half = HALF_G4;
      4'd6:    note_half = HALF_A4;
      4'd7:    note_half = HALF_B4;
      4'd8:    note_half = HALF_C5;
      default: note_half = '0;
    endcase
  endfunction

  // Tune ROM: C4 E4 G4 C5(2) rest G4 E4 C4(4)
  function automatic logic [CODE_W-1:0] rom_code(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0:    rom_code = 4'd1;
      3'd1:    rom_code = 4'd3;
      3'd2:    rom_code = 4'd5;
      3'd3:    rom_code = 4'd8;
      3'd4:    rom_code = 4'd0;
      3'd5:    rom_code = 4'd5;
      3'd6:    rom_code = 4'd3;
      default: rom_code = 4'd1;
    endcase
  endfunction

  function automatic logic [DUR_W-1:0] rom_dur(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd3:    rom_dur = 3'd2;
      3'd7:    rom_dur = 3'd4;
      default: rom_dur = 3'd1;
    endcase
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [HALF_W-1:0]   r_half_cnt;
  logic [HALF_W-1:0]   r_half;
  logic                r_rest;
  logic                r_busy;
  logic [IDX_W-1:0]    r_note_index;
  logic                r_tone;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [HALF_W-1:0]   w_half_cnt_nxt;
  logic [HALF_W-1:0]   w_half_nxt;
  logic                w_rest_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic                w_tone_nxt;
  logic                w_load;
  logic [CODE_W-1:0]   w_entry_code;
  logic [HALF_W-1:0]   w_entry_half;
  logic [CNT_W-1:0]    w_play_len;

  assign w_play_len = CNT_W'(rom_dur(r_note_index)) * CNT_W'(unit_cycles);

  // Next-state, counters and divider; stop overrides everything
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt + 32'd1;
    w_half_cnt_nxt = '0;
    w_half_nxt     = r_half;
    w_rest_nxt     = r_rest;
    w_idx_nxt      = r_note_index;
    w_tone_nxt     = 1'b0;
    w_load         = 1'b0;
    w_entry_code   = '0;
    w_entry_half   = '0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (start) begin
          w_state_nxt = S_PLAY;
          w_idx_nxt   = '0;
          w_load      = 1'b1;
        end
      end
      S_PLAY: begin
        if (r_cnt == w_play_len - 32'd1) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = '0;
        end else if (!r_rest) begin
          if (r_half_cnt == r_half - 24'd1) begin
            w_tone_nxt = ~r_tone;
          end else begin
            w_tone_nxt     = r_tone;
            w_half_cnt_nxt = r_half_cnt + 24'd1;
          end
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_nxt = '0;
          if ((r_note_index == 3'd7) && !loop) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = S_PLAY;
            w_idx_nxt   = r_note_index + 3'd1;
            w_load      = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Latch pitch of the note being entered so the divider compare is a plain register
    w_entry_code = rom_code(w_idx_nxt);
`ifdef MELODY_SEQUENCER_TRANSPOSE_EN
    w_entry_half = octave_up ? (note_half(w_entry_code) >> 1) : note_half(w_entry_code);
`else
    w_entry_half = note_half(w_entry_code);
`endif
    if (w_load) begin
      w_half_nxt = w_entry_half;
      w_rest_nxt = (w_entry_code == 4'd0);
    end

    if (stop) begin
      w_state_nxt    = S_IDLE;
      w_idx_nxt      = '0;
      w_tone_nxt     = 1'b0;
      w_cnt_nxt      = '0;
      w_half_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_half_cnt   <= '0;
      r_half       <= '0;
      r_rest       <= 1'b1;
      r_busy       <= 1'b0;
      r_note_index <= '0;
      r_tone       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_half_cnt   <= w_half_cnt_nxt;
      r_half       <= w_half_nxt;
      r_rest       <= w_rest_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_note_index <= w_idx_nxt;
      r_tone       <= w_tone_nxt;
    end
  end

  assign busy       = r_busy;
  assign note_index = r_note_index;
  assign tone       = r_tone;

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer; sample index k means "just after the k-th edge since PLAY entry".
// Halves at 100 kHz: C4=191 E4=151 G4=127 C5=95; one pass = 12*1000 + 8*50 = 12400 cycles.
module tb_melody_sequencer;

  localparam int unsigned CLK_HZ = 100000;
  localparam int unsigned UNIT   = 1000;
  localparam int unsigned GAP    = 50;
  localparam int PASS_LEN = 12400;
  localparam int DURS   [8] = '{1, 1, 1, 2, 1, 1, 1, 4};
  localparam int HALVES [8] = '{191, 151, 127, 95, 0, 127, 151, 191};

  logic       clock;
  logic       reset_n;
  logic       start;
  logic       stop;
  logic       loop;
  logic       busy;
  logic [2:0] note_index;
  logic       tone;
`ifdef MELODY_SEQUENCER_TRANSPOSE_EN
  logic       octave_up;
`endif

  int n_checks;
  int n_fails;
  int n_busy;

  melody_sequencer #(
    .clock_frequency(CLK_HZ),
    .unit_cycles    (UNIT),
    .gap_cycles     (GAP)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .stop      (stop),
    .loop      (loop),
`ifdef MELODY_SEQUENCER_TRANSPOSE_EN
    .octave_up (octave_up),
`endif
    .busy      (busy),
    .note_index(note_index),
    .tone      (tone)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected outputs at sample k after a start, for a given number of passes before going idle
  function automatic void model(input int k, input int passes,
                                output int e_idx, output bit e_tone, output bit e_busy);
    int r;
    e_idx  = 0;
    e_tone = 1'b0;
    e_busy = 1'b0;
    if (k >= passes * PASS_LEN) return;
    e_busy = 1'b1;
    r = k % PASS_LEN;
    for (int i = 0; i < 8; i++) begin
      int len;
      len = DURS[i] * int'(UNIT);
      if (r < len) begin
        e_idx  = i;
        e_tone = (HALVES[i] != 0) && (((r / HALVES[i]) % 2) == 1);
        return;
      end
      r -= len;
      if (r < int'(GAP)) begin
        e_idx = i;
        return;
      end
      r -= int'(GAP);
    end
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (note_index !== 3'd0) begin n_fails++; $display("FAIL reset_index: got %0d expected 0", note_index); end
    n_checks++; if (tone !== 1'b0) begin n_fails++; $display("FAIL reset_tone: got %b expected 0", tone); end
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL idle_after_reset: busy got %b expected 0", busy); end
  endtask

  task automatic test_start();
    do_start();
    n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL start_busy: got %b expected 1", busy); end
    n_checks++; if (note_index !== 3'd0) begin n_fails++; $display("FAIL start_index: got %0d expected 0", note_index); end
    repeat (190) @(negedge clock);
    n_checks++; if (tone !== 1'b0) begin n_fails++; $display("FAIL tone_k190: got %b expected 0", tone); end
    @(negedge clock);
    n_checks++; if (tone !== 1'b1) begin n_fails++; $display("FAIL tone_first_rise_k191: got %b expected 1", tone); end
    repeat (190) @(negedge clock);
    n_checks++; if (tone !== 1'b1) begin n_fails++; $display("FAIL tone_k381: got %b expected 1", tone); end
    @(negedge clock);
    n_checks++; if (tone !== 1'b0) begin n_fails++; $display("FAIL tone_fall_k382: got %b expected 0", tone); end
    repeat (667) @(negedge clock);
    n_checks++; if (note_index !== 3'd0 || busy !== 1'b1) begin n_fails++; $display("FAIL gap_end_k1049: idx %0d busy %b expected idx 0 busy 1", note_index, busy); end
    @(negedge clock);
    n_checks++; if (note_index !== 3'd1 || busy !== 1'b1 || tone !== 1'b0) begin n_fails++; $display("FAIL note1_entry_k1050: idx %0d busy %b tone %b expected idx 1 busy 1 tone 0", note_index, busy, tone); end
    do_stop();
  endtask

  task automatic test_full_pass();
    int ei; bit et, eb;
    loop   = 1'b0;
    n_busy = 0;
    do_start();
    for (int k = 0; k < PASS_LEN + 20; k++) begin
      model(k, 1, ei, et, eb);
      if (busy === 1'b1) n_busy++;
      n_checks++;
      if (busy !== eb || note_index !== 3'(ei) || tone !== et) begin
        n_fails++;
        $display("FAIL full_pass k=%0d: got busy %b idx %0d tone %b expected busy %b idx %0d tone %b", k, busy, note_index, tone, eb, ei, et);
        break;
      end
      @(negedge clock);
    end
    n_checks++; if (n_busy != PASS_LEN) begin n_fails++; $display("FAIL busy_length: got %0d cycles expected %0d", n_busy, PASS_LEN); end
    do_stop();
  endtask

  task automatic test_loop();
    int ei; bit et, eb;
    loop = 1'b1;
    do_start();
    for (int k = 0; k < 2 * PASS_LEN + 20; k++) begin
      // Early-pass loop changes must not matter; the mid-pass-2 drop ends the tune after pass 2
      if (k == 3000) loop = 1'b0;
      if (k == 6000) loop = 1'b1;
      if (k == PASS_LEN + 1500) loop = 1'b0;
      model(k, 2, ei, et, eb);
      n_checks++;
      if (busy !== eb || note_index !== 3'(ei) || tone !== et) begin
        n_fails++;
        $display("FAIL loop k=%0d: got busy %b idx %0d tone %b expected busy %b idx %0d tone %b", k, busy, note_index, tone, eb, ei, et);
        break;
      end
      @(negedge clock);
    end
    loop = 1'b0;
    do_stop();
  endtask

  task automatic test_stop();
    do_start();
    repeat (2400) @(negedge clock);
    n_checks++; if (note_index !== 3'd2 || busy !== 1'b1) begin n_fails++; $display("FAIL pre_stop_state: idx %0d busy %b expected idx 2 busy 1", note_index, busy); end
    do_stop();
    n_checks++; if (busy !== 1'b0 || note_index !== 3'd0 || tone !== 1'b0) begin n_fails++; $display("FAIL stop_midnote: busy %b idx %0d tone %b expected 0 0 0", busy, note_index, tone); end
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    stop  = 1'b0;
    n_checks++; if (busy !== 1'b0 || note_index !== 3'd0) begin n_fails++; $display("FAIL start_stop_same_cycle: busy %b idx %0d expected 0 0", busy, note_index); end
    repeat (3) @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL start_stop_stays_idle: busy %b expected 0", busy); end
  endtask

  task automatic test_start_while_busy();
    int ei; bit et, eb;
    do_start();
    for (int k = 0; k < 1300; k++) begin
      start = (k == 500) || (k == 1100);
      model(k, 1, ei, et, eb);
      n_checks++;
      if (busy !== eb || note_index !== 3'(ei) || tone !== et) begin
        n_fails++;
        $display("FAIL start_while_busy k=%0d: got busy %b idx %0d tone %b expected busy %b idx %0d tone %b", k, busy, note_index, tone, eb, ei, et);
        break;
      end
      @(negedge clock);
    end
    start = 1'b0;
    do_stop();
  endtask

  task automatic test_async_reset();
    int ei; bit et, eb;
    do_start();
    repeat (2400) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || note_index !== 3'd0 || tone !== 1'b0) begin n_fails++; $display("FAIL async_reset_immediate: busy %b idx %0d tone %b expected 0 0 0", busy, note_index, tone); end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    do_start();
    for (int k = 0; k < 1300; k++) begin
      model(k, 1, ei, et, eb);
      n_checks++;
      if (busy !== eb || note_index !== 3'(ei) || tone !== et) begin
        n_fails++;
        $display("FAIL after_async_reset k=%0d: got busy %b idx %0d tone %b expected busy %b idx %0d tone %b", k, busy, note_index, tone, eb, ei, et);
        break;
      end
      @(negedge clock);
    end
    do_stop();
  endtask

`ifdef MELODY_SEQUENCER_TRANSPOSE_EN
  task automatic test_transpose();
    octave_up = 1'b1;
    do_start();
    octave_up = 1'b0;
    repeat (94) @(negedge clock);
    n_checks++; if (tone !== 1'b0) begin n_fails++; $display("FAIL transpose_k94: got %b expected 0", tone); end
    @(negedge clock);
    n_checks++; if (tone !== 1'b1) begin n_fails++; $display("FAIL transpose_rise_k95: got %b expected 1", tone); end
    repeat (95) @(negedge clock);
    n_checks++; if (tone !== 1'b0) begin n_fails++; $display("FAIL transpose_fall_k190: got %b expected 0", tone); end
    repeat (1010) @(negedge clock);
    n_checks++; if (note_index !== 3'd1 || tone !== 1'b0) begin n_fails++; $display("FAIL nominal_k1200: idx %0d tone %b expected idx 1 tone 0", note_index, tone); end
    @(negedge clock);
    n_checks++; if (tone !== 1'b1) begin n_fails++; $display("FAIL nominal_rise_k1201: got %b expected 1", tone); end
    do_stop();
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fails  = 0;
    n_busy   = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    loop     = 1'b0;
`ifdef MELODY_SEQUENCER_TRANSPOSE_EN
    octave_up = 1'b0;
`endif
    test_reset();
    test_start();
    test_full_pass();
    test_loop();
    test_stop();
    test_start_while_busy();
    test_async_reset();
`ifdef MELODY_SEQUENCER_TRANSPOSE_EN
    test_transpose();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
